// File: rtl/sync_evt_capture.sv
// Debounces an already-synchronized level, emits edge pulses and keeps a
// single-entry pending-event register with a sticky overflow and a saturating edge count.
module sync_evt_capture #(
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync_in,
  input  logic       evt_ack,
  input  logic       ovf_clr,
  output logic       level_out,
  output logic       rise_pls,
  output logic       fall_pls,
  output logic       evt_valid,
  output logic       evt_type,
  output logic       evt_ovf,
  output logic [7:0] evt_cnt,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYC - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       rise_nxt, fall_nxt;
  logic       new_edge, ack_ok, ovf_set;

  // Event interface: evt_valid/evt_type are held until evt_ack is seen while
  // evt_valid=1; an ack with evt_valid=0 is ignored. An edge arriving while an
  // unacked event is pending is dropped and recorded in evt_ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= STABLE_LO;
      cnt      <= 8'd0;
      rise_pls <= 1'b0;
      fall_pls <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rise_pls <= rise_nxt;
      fall_pls <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sync_in) begin
          state_nxt = CHK_HI;
          cnt_nxt   = 8'd1;
        end
      end
      CHK_HI: begin
        if (!sync_in) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = 8'd0;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = 8'd0;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      STABLE_HI: begin
        if (!sync_in) begin
          state_nxt = CHK_LO;
          cnt_nxt   = 8'd1;
        end
      end
      CHK_LO: begin
        if (sync_in) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = 8'd0;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = 8'd0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // The debounced level is simply which half of the state space we are in.
  assign level_out = (state == STABLE_HI) || (state == CHK_LO);
  assign dbg_state = state;

  assign new_edge = rise_nxt | fall_nxt;
  assign ack_ok   = evt_ack & evt_valid;
  assign ovf_set  = new_edge & evt_valid & ~evt_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_type  <= 1'b0;
      evt_ovf   <= 1'b0;
      evt_cnt   <= 8'd0;
    end else begin
      if (new_edge) begin
        if (!ovf_set) begin
          evt_valid <= 1'b1;
          evt_type  <= rise_nxt;
        end
        if (evt_cnt != 8'hFF) evt_cnt <= evt_cnt + 8'd1;
      end else if (ack_ok) begin
        evt_valid <= 1'b0;
      end
      // A coincident new overflow beats ovf_clr.
      if (ovf_set) evt_ovf <= 1'b1;
      else if (ovf_clr) evt_ovf <= 1'b0;
    end
  end

endmodule
